regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Arbitrates two writeback sources, the execute-stage ALU (source 0) and the load/store unit (source 1), onto the single write port (we/waddr/wdata) of the register file. Each source uses a valid/ready handshake. At most one write is accepted per cycle, chosen round-robin on conflict. The accepted write is registered and presented to the register file one cycle later. Writes to register 0 are suppressed, and a saturating counter tracks conflicts for performance debug.

## Interface
- DATA_W, 32, width of write data
- ADDR_W, 5, width of register address
- CNT_W, 16, width of conflict counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  pipeline hold; when 1, no request is granted
- valid0  in  1  source 0 (ALU) write request
- addr0  in  ADDR_W  source 0 destination register
- data0  in  DATA_W  source 0 write data
- ready0  out  1  source 0 accepted this cycle (combinational)
- valid1  in  1  source 1 (LSU) write request
- addr1  in  ADDR_W  source 1 destination register
- data1  in  DATA_W  source 1 write data
- ready1  out  1  source 1 accepted this cycle (combinational)
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  ADDR_W  register file write address (registered)
- rf_wdata  out  DATA_W  register file write data (registered)
- conflict_cnt  out  CNT_W  number of cycles in which both sources were valid and stall=0, saturating

## Operation
- **State:** last_grant (1 bit), output registers rf_we/rf_waddr/rf_wdata, conflict_cnt.
- **Grant logic (combinational):**
  - If stall=1, both grants are 0.
  - Else if exactly one valid is set, grant that source.
  - Else if both are valid, grant the source that is not last_grant.
- **ready outputs:** readyN = grantN. A transfer occurs when validN & readyN.
- **Source rules:** a source must hold valid, addr and data stable until ready. Dropping valid before ready is illegal, and the bench flags it.
- **On transfer:**
  - last_grant <= granted index.
  - rf_waddr <= addrN, rf_wdata <= dataN.
  - rf_we <= 1 if addrN != 0. If addrN = 0, rf_we <= 0, but the handshake still completes (write discarded).
- **No transfer:** rf_we <= 0. rf_waddr and rf_wdata hold their previous values.
- **last_grant** changes only on a transfer. Stall cycles and single-source cycles with no transfer leave it unchanged.
- **conflict_cnt:** increments by 1 when valid0 & valid1 & ~stall. It saturates at 2^CNT_W-1 and does not wrap.
- **Reset values:**
  - rf_we=0, rf_waddr=0, rf_wdata=0, conflict_cnt=0.
  - last_grant=1, so source 0 wins the first conflict.
  - ready0/ready1 are 0 while rst=1, regardless of valid.
- **Reset mid-operation:** any granted but not-yet-written transfer is lost. rf_we is 0 in the cycle after rst is sampled high. Sources must re-present their requests after reset.

## Timing
- **Latency:** 1 cycle from handshake edge to rf_we=1 at the register file. The register file's write-through bypass covers same-cycle reads of that address.
- **Throughput:** one write per cycle sustained, e.g. alternating sources under continuous conflict.
- **Simultaneous events:**
  - Both valid with identical addr: only the granted write occurs this cycle, and the other follows next cycle. Program order across sources is the requesters' responsibility.
  - stall=1 together with both valid: no grant, and conflict_cnt does not increment.
- **Combinational paths:** ready depends combinationally on valid0, valid1, stall and last_grant. No combinational path exists from any input to rf_* outputs.

## Test plan
- **Reset:** hold rst=1 with valid0=valid1=1 for 3 cycles.
  - Required: ready0=ready1=0, rf_we=0, conflict_cnt=0 throughout.
- **Single source:** valid0=1, addr0=5, data0=0xDEADBEEF for 1 cycle.
  - Required: ready0=1 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; the cycle after, rf_we=0.
- **Conflict round-robin:** both valid continuously, addr0=1, addr1=2.
  - Required: grants alternate 0,1,0,1 starting with source 0 after reset; rf_waddr sequence 1,2,1,2; conflict_cnt increments every cycle.
- **Stall:** both valid with stall=1 for 4 cycles, then stall=0.
  - Required: no ready during stall; conflict_cnt unchanged; first grant after release goes to source 0 (last_grant still 1).
- **Register 0:** valid1=1, addr1=0, data1=0x12345678.
  - Required: ready1=1; next cycle rf_we=0; last_grant becomes 1.
- **Saturation:** with CNT_W=4, drive conflicts for 20 cycles.
  - Required: conflict_cnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that merges the ALU and LSU writeback streams onto the
// single register-file write port, with a registered write and a conflict counter.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              valid0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              ready0,
  input  logic              valid1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ready1,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic last_grant;
  logic grant0;
  logic grant1;
  logic conflict;

  assign conflict = valid0 & valid1 & ~stall;

  // On conflict the source that did not win last time gets the port.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !stall) begin
      if (valid0 && valid1) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
    end
  end

  assign ready0 = grant0;
  assign ready1 = grant1;

  // Accepted write is presented one cycle later; register 0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
    end else begin
      rf_we <= 1'b0;
      if (grant0) begin
        last_grant <= 1'b0;
        rf_waddr   <= addr0;
        rf_wdata   <= data0;
        rf_we      <= (addr0 != '0);
      end else if (grant1) begin
        last_grant <= 1'b1;
        rf_waddr   <= addr1;
        rf_wdata   <= data1;
        rf_we      <= (addr1 != '0);
      end
    end
  end

  // Saturating count of contended, unstalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != CNT_MAX)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed phases then random traffic,
// checked against a cycle-level reference model of the arbitration rules.
module tb_regfile_wb_arbiter;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0;
  logic              valid0 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0;
  logic [DATA_W-1:0] data0 = '0;
  logic              ready0;
  logic              valid1 = 1'b0;
  logic [ADDR_W-1:0] addr1 = '0;
  logic [DATA_W-1:0] data1 = '0;
  logic              ready1;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  conflict_cnt;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .valid0(valid0), .addr0(addr0), .data0(data0), .ready0(ready0),
    .valid1(valid1), .addr1(addr1), .data1(data1), .ready1(ready1),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cnt;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  // Reference model state: who won the port last, last written payload, conflicts seen.
  int                m_last = 1;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0;
  int                m_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, check the grant, and queue the expected post-edge outputs.
  task automatic step(input logic r, input logic s,
                      input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                      input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                      output logic acc0, output logic acc1);
    logic g0, g1;
    exp_t e;
    @(negedge clk);
    rst = r; stall = s;
    valid0 = v0; addr0 = a0; data0 = d0;
    valid1 = v1; addr1 = a1; data1 = d1;
    #1;
    g0 = 1'b0; g1 = 1'b0;
    if (!r && !s) begin
      if (v0 && v1) begin
        if (m_last == 1) g0 = 1'b1; else g1 = 1'b1;
      end else begin
        g0 = v0; g1 = v1;
      end
    end
    check("ready0", 64'(ready0), 64'(g0));
    check("ready1", 64'(ready1), 64'(g1));
    e.we = 1'b0;
    if (r) begin
      m_last = 1; m_addr = '0; m_data = '0; m_cnt = 0;
    end else begin
      if (v0 && v1 && !s) m_cnt++;
      if (g0) begin
        m_last = 0; m_addr = a0; m_data = d0; e.we = (a0 != 0);
      end else if (g1) begin
        m_last = 1; m_addr = a1; m_data = d1; e.we = (a1 != 0);
      end
    end
    e.addr = m_addr;
    e.data = m_data;
    e.cnt  = (m_cnt > CNT_MAX) ? CNT_MAX : m_cnt;
    sbq.push_back(e);
    acc0 = g0; acc1 = g1;
  endtask

  // Monitor: compare registered outputs just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("rf_we", 64'(rf_we), 64'(e.we));
        check("rf_waddr", 64'(rf_waddr), 64'(e.addr));
        check("rf_wdata", 64'(rf_wdata), 64'(e.data));
        check("conflict_cnt", 64'(conflict_cnt), 64'(e.cnt));
      end
    end
  end

  initial begin
    logic k0, k1;
    logic p0, p1;
    logic [ADDR_W-1:0] pa0, pa1;
    logic [DATA_W-1:0] pd0, pd1;
    logic r, s;

    for (int i = 0; i < 3; i++)
      step(1, 0, 1, 5'd3, 32'h1111, 1, 5'd4, 32'h2222, k0, k1);

    step(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, k0, k1);
    step(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, k0, k1);
    step(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, k0, k1);

    step(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, k0, k1);
    for (int i = 0; i < 6; i++)
      step(0, 0, 1, 5'd1, 32'hA000 + 32'(i), 1, 5'd2, 32'hB000 + 32'(i), k0, k1);

    for (int i = 0; i < 4; i++)
      step(0, 1, 1, 5'd7, 32'hC0C0, 1, 5'd8, 32'hD0D0, k0, k1);
    step(0, 0, 1, 5'd7, 32'hC0C0, 1, 5'd8, 32'hD0D0, k0, k1);
    step(0, 0, 0, 5'd0, 32'h0, 1, 5'd8, 32'hD0D0, k0, k1);

    step(0, 0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h12345678, k0, k1);
    step(0, 0, 1, 5'd9, 32'h9999, 1, 5'd10, 32'hAAAA, k0, k1);

    for (int i = 0; i < 20; i++)
      step(0, 0, 1, 5'(i), 32'($urandom), 1, 5'(i + 3), 32'($urandom), k0, k1);

    // Random traffic: each source holds its request until it is accepted.
    p0 = 1'b0; p1 = 1'b0;
    pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!p0 && $urandom_range(0, 99) < 60) begin
        p0 = 1'b1;
        pa0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        pd0 = 32'($urandom);
      end
      if (!p1 && $urandom_range(0, 99) < 60) begin
        p1 = 1'b1;
        pa1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        pd1 = 32'($urandom);
      end
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 9) == 0);
      step(r, s, p0, pa0, pd0, p1, pa1, pd1, k0, k1);
      if (k0) p0 = 1'b0;
      if (k1) p1 = 1'b0;
    end

    step(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, k0, k1);
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
